// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO multiply/divide controller.
//   - operation encodings presented on hilo_ctrl.op
//   - controller FSM state enum (also exported on hilo_ctrl.dbg_state)
//   - default operand width and iteration-counter width helper
package hilo_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    // Counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int HILO_WIDTH = 32;
    localparam int CNT_W      = $clog2(HILO_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shift-add multiplier /
// restoring divider.
//   acc      [2W:0]  in   accumulator; upper W+1 bits are the partial
//                         product / partial remainder, lower W bits hold the
//                         unconsumed multiplier or dividend bits
//   operand  [W-1:0] in   multiplicand (multiply) or divisor (divide)
//   is_div           in   1 = restoring-divide step, 0 = shift-add step
//   acc_nxt  [2W:0]  out  accumulator after this step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  acc,
    input  logic [WIDTH-1:0]  operand,
    input  logic              is_div,
    output logic [2*WIDTH:0]  acc_nxt
);

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] div_shl;
    logic             div_fit;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier LSB is
        // set, then shift the whole accumulator right. The extra top bit
        // catches the carry of the add.
        mul_sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, operand} : '0);

        // Divide: shift the next dividend bit into the remainder, then keep
        // the subtraction only if the divisor fits (restore otherwise).
        div_shl = {acc[2*WIDTH-1:0], 1'b0};
        div_fit = (div_shl[2*WIDTH:WIDTH] >= {1'b0, operand});

        if (is_div) begin
            acc_nxt = div_shl;
            if (div_fit) begin
                acc_nxt[2*WIDTH:WIDTH] = div_shl[2*WIDTH:WIDTH] - {1'b0, operand};
                acc_nxt[0]             = 1'b1;
            end
        end else begin
            acc_nxt = {1'b0, mul_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: sequencing controller for the multiply/divide unit and owner of
// the architectural HI/LO registers.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start, op, a, b   operation request (op: MULT/MULTU/DIV/DIVU)
//   wr_hi, wr_lo,
//   wr_data           MTHI / MTLO writes
//   rd_req            MFHI / MFLO waiting in execute
//   busy              operation in flight (state != IDLE)
//   stall             rd_req & busy (combinational)
//   done              one-cycle pulse after HI/LO take an operation result
//   hi, lo            HI / LO registers
//   dbg_state         current FSM state, for observation only
//
// Handshake: a request is accepted on a rising edge where start=1, busy=0 and
// neither wr_hi nor wr_lo is asserted; a start seen while busy is dropped, not
// queued. Completion is signalled by busy falling together with done rising.
// An MTHI/MTLO write always wins: it aborts any operation in flight.
//
// Build option: HILO_EARLY_TERM_EN - when defined, a multiply leaves RUN as
// soon as the remaining multiplier bits are all zero.
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output state_e           dbg_state
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    state_e           state, state_nxt;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [AW-1:0]    acc, acc_step;
    logic [WIDTH-1:0] opnd;
    logic [CW-1:0]    cnt;
    logic             neg_q;      // negate quotient / full product
    logic             neg_r;      // negate remainder
    logic             wr_any;
    logic             is_div, is_signed, div_zero;
    logic             early_term;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] res_hi, res_lo;

    assign wr_any    = wr_hi | wr_lo;
    assign is_div    = (op_q == OP_DIV)  || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign div_zero  = is_div && (b_q == '0);
    assign a_mag     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    assign b_mag     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .operand (opnd),
        .is_div  (is_div),
        .acc_nxt (acc_step)
    );

`ifdef HILO_EARLY_TERM_EN
    // After the step taken at counter value cnt, the multiplier bits still
    // to be consumed sit in acc_step[cnt-1:0].
    logic mul_rest_zero;
    always_comb begin
        mul_rest_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if ((CW'(i) < cnt) && acc_step[i]) mul_rest_zero = 1'b0;
        end
    end
    assign early_term = !is_div && mul_rest_zero;
`else
    assign early_term = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (wr_any) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start) state_nxt = ST_PREP;
                ST_PREP: state_nxt = div_zero ? ST_FIX : ST_RUN;
                ST_RUN:  if ((cnt == '0) || early_term) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        stall     = rd_req & busy;
        dbg_state = state;
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MULT;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !wr_any) begin
                        op_q <= op;
                        a_q  <= a;
                        b_q  <= b;
                    end
                end
                ST_PREP: begin
                    cnt   <= CW'(WIDTH - 1);
                    neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= is_signed & a_q[WIDTH-1];
                    opnd  <= is_div ? b_mag : a_mag;
                    acc   <= {{(WIDTH+1){1'b0}}, (is_div ? a_mag : b_mag)};
                end
                ST_RUN: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
`ifdef HILO_EARLY_TERM_EN
                    // Skipped steps would only shift right; apply them at once.
                    acc <= early_term ? (acc_step >> cnt) : acc_step;
`else
                    acc <= acc_step;
`endif
                end
                default: ;
            endcase
        end
    end

    // Sign correction of the magnitude result.
    always_comb begin
        prod   = neg_q ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (div_zero) begin
            res_hi = a_q;
            res_lo = '1;
        end else if (is_div) begin
            res_lo = neg_q ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
            res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    // HI/LO: software writes take priority over (and cancel) a result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_any) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
            end else if (state == ST_FIX) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: directed and randomized checks of hilo_ctrl against a
// plain-arithmetic model of MULT/MULTU/DIV/DIVU and MTHI/MTLO.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    // ------------------------------------------------ clock / reset block
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, wr_hi, wr_lo, rd_req;
    logic [1:0]  op;
    logic [31:0] a, b, wr_data;
    logic        busy, stall, done;
    logic [31:0] hi, lo;
    state_e      dbg_state;

    always #5 clk = ~clk;

    hilo_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .wr_hi     (wr_hi),
        .wr_lo     (wr_lo),
        .wr_data   (wr_data),
        .rd_req    (rd_req),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ------------------------------------------------------- scoreboard
    logic [63:0] exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint      sx, sy, q, m;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = 64'(sx * sy);
            2'b01: r = {32'd0, x} * {32'd0, y};
            2'b10: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else begin
                    q = sx / sy;
                    m = sx % sy;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
                else            r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    // Rising edges from the one sampling start up to the one writing HI/LO.
    function automatic int exp_latency(input logic [1:0] o, input logic [31:0] y);
        if (o[1] && (y == 32'd0)) return 3;
`ifdef HILO_EARLY_TERM_EN
        if (!o[1]) begin
            logic [31:0] m;
            int          n;
            m = (!o[0] && y[31]) ? -y : y;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return 3 + n;
        end
`endif
        return 35;
    endfunction

    // ---------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke_start, input bit watch_stall);
        int lat;
        int n_done;
        exp_q.push_back(ref_model(o, x, y));
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
        lat = 1;
        n_done = 0;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (busy && lat < 100) begin
            if (watch_stall) chk("stall_while_busy", 64'(stall), 64'd1);
            if (poke_start && lat == 5) begin
                start = 1'b1; op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom;
            end
            step();
            start = 1'b0;
            lat++;
            if (done) n_done++;
        end
        chk("latency", 64'(lat), 64'(exp_latency(o, y)));
        chk("done_at_update", 64'(done), 64'd1);
        if (watch_stall) chk("stall_drop", 64'(stall), 64'd0);
        chk("hilo_result", {hi, lo}, exp_q.pop_front());
        {model_hi, model_lo} = ref_model(o, x, y);
        step();
        if (done) n_done++;
        chk("done_once", 64'(n_done), 64'd1);
    endtask

    // --------------------------------------------------------- stimulus
    logic [31:0] corner[5];
    logic [31:0] x, y, d;

    initial begin
        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0; rd_req = 1'b1;

        // Reset state
        step(); step();
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        rst_n = 1'b1;
        rd_req = 1'b0;
        step();

        // Directed operations
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
        run_op(OP_DIVU,  32'd100,       32'd0,         1'b0, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(OP_DIV,   32'd17,        32'd0,         1'b0, 1'b0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);

        // Read stall across a whole operation
        rd_req = 1'b1;
        run_op(OP_MULTU, 32'd6, 32'd7, 1'b0, 1'b1);
        rd_req = 1'b0;

        // MTHI/MTLO in IDLE, together and singly
        d = $urandom;
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = d;
        step();
        wr_hi = 1'b0; wr_lo = 1'b0;
        model_hi = d; model_lo = d;
        chk("mt_both", {hi, lo}, {model_hi, model_lo});
        d = $urandom;
        wr_hi = 1'b1; wr_data = d;
        step();
        wr_hi = 1'b0;
        model_hi = d;
        chk("mthi_only", {hi, lo}, {model_hi, model_lo});

        // start together with a write: write wins, start dropped
        d = $urandom;
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5; wr_lo = 1'b1; wr_data = d;
        step();
        start = 1'b0; wr_lo = 1'b0;
        model_lo = d;
        chk("start_wr_busy", 64'(busy), 64'd0);
        chk("start_wr_hilo", {hi, lo}, {model_hi, model_lo});
        step();
        chk("start_wr_no_done", 64'(done), 64'd0);

        // Abort by MTLO at RUN cycle 10
        start = 1'b1; op = OP_MULTU; a = $urandom; b = $urandom | 32'h8000_0000;
        step();
        start = 1'b0;
        repeat (11) step();
        chk("abort_in_run", 64'(dbg_state), 64'(ST_RUN));
        wr_lo = 1'b1; wr_data = 32'h55;
        step();
        wr_lo = 1'b0;
        model_lo = 32'h55;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, {model_hi, model_lo});
        chk("abort_no_done", 64'(done), 64'd0);
        step();
        chk("abort_no_done_later", 64'(done), 64'd0);

        // Asynchronous reset mid-RUN
        start = 1'b1; op = OP_DIVU; a = $urandom; b = $urandom_range(1, 1000);
        step();
        start = 1'b0;
        repeat (15) step();
        rst_n = 1'b0;
        #1;
        model_hi = 32'd0; model_lo = 32'd0;
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        step();
        rst_n = 1'b1;
        step();

        // Randomized operations
        for (int k = 0; k < 24; k++) begin
            x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            case ($urandom_range(0, 5))
                0:       y = corner[$urandom_range(0, 4)];
                1:       y = 32'($urandom_range(1, 15));
                2:       y = -32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            rd_req = 1'($urandom_range(0, 1));
            run_op(2'($urandom_range(0, 3)), x, y, 1'($urandom_range(0, 1)), 1'b0);
        end
        rd_req = 1'b0;

        // ----------------------------------------------------- report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
